// File: rtl/adder_rr_scheduler_if.sv
// Request/response bundle between the client blocks and the shared adder scheduler.
// Requester i owns bit i of req_valid/req_ready and slice [i*WIDTH +: WIDTH] of req_a/req_b.
interface adder_rr_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH:0]        rsp_sum;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;
  logic [15:0]           ops_done;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, busy, ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, busy, ops_done
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin arbiter in front of one registered adder; every addition is serialised
// through IDLE -> ADD -> RESP and returned with the winning requester's index.
module adder_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic               clk,
  input logic               rst,
  adder_rr_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t          state, next_state;
  logic [IDW-1:0]  ptr;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]  sum_q;
  logic [IDW-1:0]  id_q;
  logic [15:0]     ops_q;

  logic            found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;
  logic [IDW:0]    ptr_inc;
  logic [IDW-1:0]  ptr_next;
  logic [NREQ-1:0] grant_onehot;
  logic            handshake;

  // Scan from ptr upward with wrap; first valid requester wins.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc  = {1'b0, grant_idx} + (IDW+1)'(1);
    ptr_next = (ptr_inc == (IDW+1)'(NREQ)) ? '0 : ptr_inc[IDW-1:0];
  end

  // Grants exist only in IDLE; gating with rst keeps req_ready low throughout reset.
  assign grant_onehot  = found ? (NREQ'(1) << grant_idx) : '0;
  assign bus.req_ready = (state == IDLE && !rst) ? grant_onehot : '0;
  assign handshake     = |(bus.req_valid & bus.req_ready);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (handshake) next_state = ADD;
      ADD:     next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Datapath registers are few and small, so all of them take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      sum_q <= '0;
      id_q  <= '0;
      ops_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (handshake) begin
          op_a <= bus.req_a[grant_idx*WIDTH +: WIDTH];
          op_b <= bus.req_b[grant_idx*WIDTH +: WIDTH];
          id_q <= grant_idx;
          ptr  <= ptr_next;
        end
        ADD:  sum_q <= {1'b0, op_a} + {1'b0, op_b};
        RESP: if (bus.rsp_ready) ops_q <= ops_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_id    = id_q;
  assign bus.ops_done  = ops_q;
endmodule

// File: doc/adder_rr_scheduler.md
# adder_rr_scheduler

Shares one registered WIDTH-bit adder among NREQ requesters. Each request carries its own operand pair over a valid/ready handshake, and a round-robin pointer picks the winner. The block computes the (WIDTH+1)-bit sum and returns it with the winner's index over a single backpressured response channel. It sits between several client blocks and the adder datapath, and serialises all additions through one adder instance.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; sum width is WIDTH+1
- NREQ, 4, number of requesters, legal range 2..8; IDW = $clog2(NREQ)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, at most one bit set (one-hot or zero)
- req_a  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing as req_a
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer accept
- rsp_sum  out  WIDTH+1  registered sum
- rsp_id  out  IDW  index of the requester that owns rsp_sum
- busy  out  1  high whenever the state is not IDLE
- ops_done  out  16  count of completed operations (response handshakes)

## Operation
- FSM states: IDLE, ADD, RESP.
- IDLE, arbitration:
  - Scan req_valid starting at ptr, ascending, wrapping at NREQ-1 -> 0.
  - The first set bit wins (index g). req_ready[g]=1 combinationally; it is only ever asserted in IDLE.
- IDLE, on req_valid[g] & req_ready[g]:
  - Latch req_a/req_b slice g into op_a/op_b, and g into rsp_id.
  - ptr <= (g+1) mod NREQ.
  - Go to ADD.
- IDLE with no valid: stay; ptr unchanged.
- ADD: rsp_sum <= zero-extended op_a + zero-extended op_b (full WIDTH+1 bits, never truncated); go to RESP.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id held stable.
  - On rsp_ready: ops_done <= ops_done+1 (wraps 65535 -> 0), then go to IDLE.
  - Without rsp_ready: stay, outputs unchanged.
- Requesters keep req_valid and operands stable until their handshake. Dropping req_valid before a grant is legal; arbitration uses current-cycle req_valid only.
- rsp_ready is ignored outside RESP.
- Reset values:
  - state IDLE, ptr 0
  - rsp_valid 0, rsp_sum 0, rsp_id 0
  - ops_done 0, busy 0, req_ready all 0 while rst is high
  - op_a/op_b 0

## Timing
- Request handshake at edge E0 -> ADD during the cycle after E0 -> RESP after E1, so rsp_valid is high in the cycle following edge E1.
- Latency is 2 cycles from request handshake to rsp_valid.
- When rsp_ready is high on the first RESP cycle, the response completes at E2 and IDLE can accept a new request in the cycle after E2. Peak throughput is therefore 1 operation per 3 cycles.
- While the block is not in IDLE, no req_ready is asserted; pending requests wait.
- rsp_ready already high when RESP is entered: the response completes in a single RESP cycle.
- Single requester continuously valid: it is re-granted on every IDLE pass (the pointer wraps past the other requesters).
- Reset asserted in ADD or RESP:
  - The in-flight operation is discarded; no response is ever produced for it.
  - ptr returns to 0 and ops_done returns to 0.
- Release of rst is synchronised externally to clk; the block has no reset synchroniser.

## Test plan
- Reset: hold rst with random inputs -> req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, ops_done=0, busy=0; after release, first idle cycle with no requests keeps all outputs at these values.
- Single request: WIDTH=8, NREQ=4, requester 1 with a=200, b=100, rsp_ready=1 -> req_ready=4'b0010 for one cycle; rsp_valid 2 cycles after the handshake; rsp_sum=300 (9'h12C), rsp_id=1; ops_done=1.
- Round-robin fairness: all four req_valid held high, rsp_ready=1, requester i sends a=i, b=10 -> grants in order 0,1,2,3,0,1; sums 10,11,12,13,10,11; a new grant every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_sum and rsp_id stable; req_ready=0 throughout; ops_done unchanged; raising rsp_ready completes on that edge and ops_done increments by 1.
- Width boundary: a=255, b=255 -> rsp_sum=510 (9'h1FE); a=0, b=0 -> rsp_sum=0.
- Reset mid-operation: assert rst during ADD for requester 2 (a=7, b=9) -> no rsp_valid after release; ptr=0, so with all requesters valid, requester 0 is granted first; ops_done=0.
